// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and line levels for the UART transmit path
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int   UART_DATA_BITS   = 8;
  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO decoupling the producer from the serialiser
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic [UART_DATA_BITS-1:0]       push_data,
  input  logic                            pop,
  output logic [UART_DATA_BITS-1:0]       pop_data,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(DEPTH+1)-1:0]      count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [UART_DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic                      push_ok;
  logic                      pop_ok;

  // Guarded strobes: a push into a full FIFO never overwrites queued data.
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8E1 UART serialiser: FIFO, baud counter, frame FSM
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ     = 50000000,
  parameter int BAUD_RATE      = 9600,
  parameter int CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic [7:0]                         tx_data,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  output logic                               tx,
  output logic                               busy,
  output logic                               frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int                CW        = $clog2(CYCLES_PER_BIT);
  localparam logic [CW-1:0]     BAUD_LAST = CW'(CYCLES_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t            state, next_state;
  logic [CW-1:0]             baud_cnt, baud_next;
  logic [2:0]                bit_idx, bit_idx_next;
  logic [UART_DATA_BITS-1:0] shift, shift_next;
  logic                      parity, parity_next;
  logic                      tx_next;
  logic                      bit_end;
  logic                      can_start;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_data;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign tx_ready   = ~fifo_full;
  assign busy       = (state != IDLE);
  assign bit_end    = (baud_cnt == BAUD_LAST);
  assign can_start  = enable & ~fifo_empty;
  assign frame_done = (state == STOP) && bit_end;

  always_comb begin
    next_state   = state;
    fifo_pop     = 1'b0;
    shift_next   = shift;
    parity_next  = parity;
    bit_idx_next = bit_idx;
    baud_next    = '0;
    tx_next      = UART_IDLE_LEVEL;

    case (state)
      IDLE: begin
        if (can_start) begin
          fifo_pop   = 1'b1;
          next_state = START;
        end
      end
      START: begin
        if (bit_end) begin
          next_state   = DATA;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next   = shift >> 1;
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == LAST_BIT) next_state = PARITY;
        end
      end
      PARITY: begin
        if (bit_end) next_state = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (can_start) begin
            fifo_pop   = 1'b1;
            next_state = START;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase

    if (fifo_pop) begin
      shift_next  = fifo_data;
      parity_next = ^fifo_data;
    end

    // Counter restarts on every state entry and idles at zero.
    if (state != IDLE && next_state == state && !bit_end) baud_next = baud_cnt + CW'(1);

    // tx is registered from the post-edge state so line and state move together.
    case (next_state)
      START:   tx_next = UART_START_LEVEL;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      parity   <= 1'b0;
      tx       <= UART_IDLE_LEVEL;
    end else begin
      state    <= next_state;
      baud_cnt <= baud_next;
      bit_idx  <= bit_idx_next;
      shift    <= shift_next;
      parity   <= parity_next;
      tx       <= tx_next;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - randomized and directed bench against a frame-level reference model
module tb_uart_transmitter;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 11 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  uart_transmitter #(
    .CLOCK_FREQ (8),
    .BAUD_RATE  (2),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done),
    .fifo_count (fifo_count)
  );

  int checks = 0;
  int errors = 0;
  int busy_cycles = 0;
  int done_pulses = 0;

  // Model: queued bytes, byte on the line, and cycles left in the current frame.
  byte unsigned q[$];
  logic [7:0]   cur = 8'h00;
  int           rem = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame = start, 8 data LSB first, even parity, stop; each level lasts CPB cycles.
  function automatic logic model_tx();
    int idx;
    if (rem == 0) return 1'b1;
    idx = (FRAME - rem) / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return cur[idx-1];
    if (idx == 9) return ^cur;
    return 1'b1;
  endfunction

  task automatic model_step();
    logic push_ok;
    logic pop;
    push_ok = tx_valid && (q.size() < DEPTH);
    pop     = enable && (q.size() > 0) && (rem <= 1);
    if (pop) begin
      cur = q.pop_front();
      rem = FRAME;
    end else if (rem > 0) begin
      rem--;
    end
    if (push_ok) q.push_back(tx_data);
  endtask

  task automatic check_outputs();
    check_eq("tx",         32'(tx),         32'(model_tx()));
    check_eq("busy",       32'(busy),       32'(rem != 0));
    check_eq("frame_done", 32'(frame_done), 32'(rem == 1));
    check_eq("fifo_count", 32'(fifo_count), 32'(q.size()));
    check_eq("tx_ready",   32'(tx_ready),   32'(q.size() < DEPTH));
    if (busy) busy_cycles++;
    if (frame_done) done_pulses++;
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic en);
    tx_valid = v;
    tx_data  = d;
    enable   = en;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drain();
    int n = 0;
    while ((rem != 0 || q.size() != 0) && n < 20 * FRAME) begin
      cycle(1'b0, 8'h00, 1'b1);
      n++;
    end
    cycle(1'b0, 8'h00, 1'b1);
    check_eq("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic run_until_rem(input int target, input logic en);
    int n = 0;
    while (rem != target && n < 20 * FRAME) begin
      cycle(1'b0, 8'h00, en);
      n++;
    end
    check_eq("reach_point", 32'(rem), 32'(target));
  endtask

  task automatic clear_stats();
    busy_cycles = 0;
    done_pulses = 0;
  endtask

  initial begin
    @(negedge clk);
    check_eq("rst_tx",         32'(tx),         32'd1);
    check_eq("rst_busy",       32'(busy),       32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    check_eq("rst_fifo_count", 32'(fifo_count), 32'd0);
    check_eq("rst_tx_ready",   32'(tx_ready),   32'd1);
    rst = 1'b0;

    // Single frame: 0x55, then 0x07 (odd weight, parity 1).
    clear_stats();
    cycle(1'b1, 8'h55, 1'b1);
    drain();
    check_eq("s1_busy_cycles", 32'(busy_cycles), 32'd44);
    check_eq("s1_done_pulses", 32'(done_pulses), 32'd1);
    clear_stats();
    cycle(1'b1, 8'h07, 1'b1);
    drain();
    check_eq("s2_busy_cycles", 32'(busy_cycles), 32'd44);

    // Fill the FIFO with enable low so the fifth offer is refused, then re-offer.
    clear_stats();
    for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(i), 1'b0);
    check_eq("s3_fifo_full", 32'(fifo_count), 32'd4);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h05, 1'b1);
    drain();
    check_eq("s3_busy_cycles", 32'(busy_cycles), 32'd220);
    check_eq("s3_done_pulses", 32'(done_pulses), 32'd5);

    // enable gating: hold, release, drop mid-DATA.
    cycle(1'b1, 8'hA3, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b0);
    check_eq("s4_held_tx",    32'(tx),         32'd1);
    check_eq("s4_held_count", 32'(fifo_count), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);
    check_eq("s4_start_tx", 32'(tx), 32'd0);
    run_until_rem(FRAME - 4 * CPB, 1'b1);
    cycle(1'b1, 8'h5A, 1'b0);
    run_until_rem(0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b0);
    check_eq("s4_after_tx",    32'(tx),         32'd1);
    check_eq("s4_after_count", 32'(fifo_count), 32'd1);
    drain();

    // Asynchronous reset during data bit 3, with a byte still queued.
    cycle(1'b1, 8'hC6, 1'b1);
    cycle(1'b1, 8'h9B, 1'b1);
    run_until_rem(FRAME - 4 * CPB - 1, 1'b1);
    #1 rst = 1'b1;
    #1;
    check_eq("s5_rst_tx",         32'(tx),         32'd1);
    check_eq("s5_rst_busy",       32'(busy),       32'd0);
    check_eq("s5_rst_count",      32'(fifo_count), 32'd0);
    check_eq("s5_rst_frame_done", 32'(frame_done), 32'd0);
    q.delete();
    rem = 0;
    @(posedge clk);
    @(negedge clk);
    check_eq("s5_hold_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    cycle(1'b1, 8'h3C, 1'b1);
    drain();

    // Push in the last stop cycle with one byte queued: count unchanged.
    cycle(1'b1, 8'h11, 1'b1);
    cycle(1'b1, 8'h22, 1'b1);
    run_until_rem(1, 1'b1);
    check_eq("s6_pre_count", 32'(fifo_count), 32'd1);
    cycle(1'b1, 8'h33, 1'b1);
    check_eq("s6_post_count", 32'(fifo_count), 32'd1);
    drain();

    // Random traffic with occasional enable drops.
    for (int i = 0; i < 1500; i++)
      cycle(1'($urandom_range(0, 2) == 0), 8'($urandom), 1'($urandom_range(0, 7) != 0));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
